// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-byte fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous byte FIFO for prefetched instruction bytes.
// Clear wins over push and pop; push and pop together are legal when non-empty.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_pop;

    // DEPTH is a power of two, so pointers wrap naturally
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1) return '0;
        return p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign head   = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, prefetches bytes over a single-outstanding
// req/ack port, flushes on jump. Build with FETCH_BYPASS_EN for same-cycle bypass.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcc,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [7:0]        fetch_data,
    output logic              fetch_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic [ADDR_W-1:0] fptr;
    logic [ADDR_W-1:0] fptr_n;
    logic [ADDR_W-1:0] pc_n;
    logic [ADDR_W-1:0] addr_n;
    logic              req_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [7:0]        head;
    logic              ack_live;
    logic              byp;
    logic              consume;
    logic              push;
    logic              pop;
    logic              room;

    // An ack only carries usable data in BUSY and when no jump is flushing it
    assign ack_live = mem_ack && (state == BUSY) && !jmp;

`ifdef FETCH_BYPASS_EN
    assign byp = ack_live && (count == '0);
`else
    assign byp = 1'b0;
`endif

    assign fetch_valid = (count != '0) || byp;
    assign fetch_data  = byp ? mem_data : head;
    assign stall       = pcc && !fetch_valid;
    assign consume     = pcc && fetch_valid && !jmp;
    assign pop         = consume && (count != '0);
    assign push        = ack_live && !(byp && pcc);
    assign count_n     = jmp ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    assign room        = count_n < CNT_W'(DEPTH);

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (jmp),
        .push  (push),
        .pop   (pop),
        .din   (mem_data),
        .head  (head),
        .count (count)
    );

    always_comb begin
        state_n = state;
        req_n   = mem_req;
        addr_n  = mem_addr;
        pc_n    = pc;
        fptr_n  = fptr;

        if (consume)
            pc_n = pc + ADDR_W'(1);
        if (jmp) begin
            pc_n   = jmp_addr;
            fptr_n = jmp_addr;
        end

        case (state)
            IDLE: begin
                if (!jmp && room) begin
                    req_n   = 1'b1;
                    addr_n  = fptr;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (jmp) begin
                    // The in-flight request cannot be withdrawn; let it drain in DISCARD
                    if (mem_ack) begin
                        req_n   = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = DISCARD;
                    end
                end else if (mem_ack) begin
                    fptr_n = fptr + ADDR_W'(1);
                    if (room) begin
                        addr_n = fptr + ADDR_W'(1);
                    end else begin
                        req_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            pc       <= '0;
            fptr     <= '0;
        end else begin
            state    <= state_n;
            mem_req  <= req_n;
            mem_addr <= addr_n;
            pc       <= pc_n;
            fptr     <= fptr_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch against a behavioural program memory (byte = addr ^ A5).
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcc = 1'b0;
    logic        jmp = 1'b0;
    logic [15:0] jmp_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [7:0]  fetch_data;
    logic        fetch_valid;
    logic        stall;
    logic [15:0] pc;

    int   n_checks = 0;
    int   n_errors = 0;
    int   consumed = 0;
    int   wait_n   = 0;
    int   wcnt     = 0;
    logic auto_ack = 1'b1;
    logic man_ack  = 1'b0;
    logic [7:0] man_data = 8'h3C;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } sb_t;
    sb_t         sb_q[$];
    sb_t         sb_e;
    logic [15:0] req_log[$];

    logic        hold_chk = 1'b0;
    logic [15:0] hold_addr = '0;
    logic        rst_d = 1'b1;
    logic        seen_valid;
    logic        found;
    int          stall_cnt;
    int          base;

    pc_fetch #(.ADDR_W(16), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pcc         (pcc),
        .jmp         (jmp),
        .jmp_addr    (jmp_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memv(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Program memory: ack after wait_n wait cycles, or a manual strobe from the bench
    always @(posedge clk) wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;
    assign mem_ack  = (auto_ack && mem_req && (wcnt >= wait_n)) || man_ack;
    assign mem_data = man_ack ? man_data : memv(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_load(input logic [15:0] a);
        logic [15:0] x;
        sb_q.delete();
        for (int i = 0; i < 32; i++) begin
            x = a + 16'(i);
            sb_q.push_back('{addr: x, data: memv(x)});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pcc = 1'b0; jmp = 1'b0; man_ack = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_pc", pc, 16'h0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_valid", fetch_valid, 1'b0);
        chk("rst_data", fetch_data, 8'h00);
        cyc();
        sb_load(16'h0000);
        req_log.delete();
        consumed = 0;
        rst = 1'b0;
    endtask

    // Consumption scoreboard, request log and request-hold monitor
    always @(negedge clk) begin
        if (!rst && pcc && fetch_valid && !jmp) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_pc", pc, sb_e.addr);
                chk("sb_data", fetch_data, sb_e.data);
                consumed++;
            end
        end
        if (mem_req && mem_ack)
            req_log.push_back(mem_addr);
        if (hold_chk && !rst_d) begin
            chk("hold_req", mem_req, 1'b1);
            chk("hold_addr", mem_addr, hold_addr);
        end
    end

    always @(posedge clk) begin
        hold_chk  <= mem_req && !mem_ack;
        hold_addr <= mem_addr;
        rst_d     <= rst;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait memory, pcc held high
        wait_n = 0; auto_ack = 1'b1;
        do_reset();
        pcc = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (seen_valid) chk("zw_stall", stall, 1'b0);
            if (fetch_valid) seen_valid = 1'b1;
            cyc();
        end
        pcc = 1'b0;
        chk("zw_progress", consumed >= 10, 1'b1);

        // Three wait states, pcc held high
        wait_n = 3;
        do_reset();
        pcc = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            cyc();
        end
        pcc = 1'b0;
        chk("ws_stall_gaps", stall_cnt > 0, 1'b1);
        chk("ws_progress", consumed >= 6, 1'b1);

        // FIFO full, stray ack in IDLE, one pop releases the next request
        wait_n = 0;
        do_reset();
        repeat (8) cyc();
        @(negedge clk);
        chk("full_nreq", req_log.size(), 2);
        chk("full_req0", req_log.size() > 0 ? req_log[0] : 16'hDEAD, 16'h0000);
        chk("full_req1", req_log.size() > 1 ? req_log[1] : 16'hDEAD, 16'h0001);
        chk("full_idle", mem_req, 1'b0);
        chk("full_valid", fetch_valid, 1'b1);
        chk("full_pc", pc, 16'h0000);
        cyc();
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        pcc = 1'b1;
        cyc();
        pcc = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("full_nreq_after", req_log.size(), 3);
        chk("full_req2", req_log.size() > 2 ? req_log[2] : 16'hDEAD, 16'h0002);
        chk("full_pc_after", pc, 16'h0001);
        chk("full_consumed", consumed, 1);

        // Jump while a request to 0x0005 is outstanding; its ack comes 2 cycles later
        auto_ack = 1'b0;
        do_reset();
        cyc();
        @(negedge clk);
        chk("j_req0", mem_req, 1'b1);
        cyc();
        jmp = 1'b1; jmp_addr = 16'h0005;
        cyc();
        jmp = 1'b0;
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        cyc();
        @(negedge clk);
        chk("j_req5", mem_req, 1'b1);
        chk("j_addr5", mem_addr, 16'h0005);
        cyc();
        jmp = 1'b1; jmp_addr = 16'h1234;
        sb_load(16'h1234);
        cyc();
        jmp = 1'b0;
        @(negedge clk);
        chk("j_pc", pc, 16'h1234);
        chk("j_valid", fetch_valid, 1'b0);
        chk("j_hold_addr", mem_addr, 16'h0005);
        cyc();
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        auto_ack = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1'b1;
            end else begin
                chk("j_wait_pc", pc, 16'h1234);
                chk("j_wait_valid", fetch_valid, 1'b0);
                cyc();
            end
        end
        chk("j_new_req", found, 1'b1);
        chk("j_new_addr", mem_addr, 16'h1234);
        base = consumed;
        cyc();
        pcc = 1'b1;
        repeat (6) cyc();
        pcc = 1'b0;
        chk("j_progress", consumed - base >= 3, 1'b1);

        // jmp and pcc together with two bytes buffered
        do_reset();
        repeat (6) cyc();
        @(negedge clk);
        chk("jp_full_valid", fetch_valid, 1'b1);
        chk("jp_full_idle", mem_req, 1'b0);
        cyc();
        jmp = 1'b1; jmp_addr = 16'h0040; pcc = 1'b1;
        sb_load(16'h0040);
        base = consumed;
        cyc();
        jmp = 1'b0; pcc = 1'b0;
        @(negedge clk);
        chk("jp_pc", pc, 16'h0040);
        chk("jp_empty", fetch_valid, 1'b0);
        chk("jp_no_consume", consumed, base);
        cyc();
        pcc = 1'b1;
        repeat (8) cyc();
        pcc = 1'b0;
        repeat (6) cyc();

        // Wrap-around from 0xFFFF
        @(negedge clk);
        chk("wr_idle", mem_req, 1'b0);
        cyc();
        jmp = 1'b1; jmp_addr = 16'hFFFF;
        sb_load(16'hFFFF);
        req_log.delete();
        cyc();
        jmp = 1'b0;
        repeat (5) cyc();
        @(negedge clk);
        chk("wr_req0", req_log.size() > 0 ? req_log[0] : 16'hDEAD, 16'hFFFF);
        chk("wr_req1", req_log.size() > 1 ? req_log[1] : 16'hDEAD, 16'h0000);
        chk("wr_pc0", pc, 16'hFFFF);
        cyc();
        pcc = 1'b1;
        cyc();
        cyc();
        pcc = 1'b0;
        @(negedge clk);
        chk("wr_pc2", pc, 16'h0001);

        // Reset while a request is outstanding, then a late ack in IDLE
        auto_ack = 1'b0;
        do_reset();
        cyc();
        @(negedge clk);
        chk("rm_req", mem_req, 1'b1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        man_ack = 1'b1;
        @(negedge clk);
        chk("rm_req_drop", mem_req, 1'b0);
        cyc();
        man_ack = 1'b0;
        auto_ack = 1'b1;
        sb_load(16'h0000);
        consumed = 0;
        pcc = 1'b1;
        repeat (6) cyc();
        pcc = 1'b0;
        chk("rm_progress", consumed >= 3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
